// File: rtl/oflow_match_search.sv
// oflow_match_search
// Nearest-neighbour search of the current object against a small table of
// objects from the previous frame. The score is the L1 distance over centre of
// mass and size. One table entry is evaluated per cycle, and the lowest score
// wins. A tie keeps the lowest index.
module oflow_match_search #(
    parameter int unsigned THRESHOLD = 200
) (
    input  logic        clk,
    input  logic        reset_N,
    input  logic        prev_wr_en,
    input  logic [2:0]  prev_wr_addr,
    input  logic [21:0] prev_cm_concate,
    input  logic [10:0] prev_width,
    input  logic [10:0] prev_height,
    input  logic [3:0]  prev_count,
    input  logic        start,
    input  logic [21:0] cm_concate,
    input  logic [10:0] width,
    input  logic [10:0] height,
    output logic        busy,
    output logic        done,
    output logic [2:0]  best_idx,
    output logic [12:0] best_score,
    output logic        match_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned ENTRIES   = 8;
    localparam logic [12:0] SCORE_MAX = 13'd8191;

    // Absolute difference of two unsigned 11-bit values. It never wraps.
    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Previous-frame object table
    logic [10:0] tab_cx [ENTRIES];
    logic [10:0] tab_cy [ENTRIES];
    logic [10:0] tab_w  [ENTRIES];
    logic [10:0] tab_h  [ENTRIES];

    // Search state
    logic [1:0]  state;
    logic [10:0] cur_cx, cur_cy, cur_w, cur_h;
    logic [3:0]  scan_cnt;
    logic [2:0]  scan_idx;
    logic [12:0] run_min;
    logic [2:0]  run_idx;

    // Combinational scoring of the entry under scan
    logic [10:0] d_cx, d_cy, d_w, d_h;
    logic [12:0] score;
    logic [12:0] next_min;
    logic [2:0]  next_idx;
    logic        last_entry;
    logic [3:0]  count_clamped;

    assign count_clamped = (prev_count > 4'd8) ? 4'd8 : prev_count;
    assign last_entry    = ({1'b0, scan_idx} == (scan_cnt - 4'd1));

    assign d_cx  = abs_diff(cur_cx, tab_cx[scan_idx]);
    assign d_cy  = abs_diff(cur_cy, tab_cy[scan_idx]);
    assign d_w   = abs_diff(cur_w,  tab_w[scan_idx]);
    assign d_h   = abs_diff(cur_h,  tab_h[scan_idx]);
    // Four 11-bit terms need at most 13 bits (4 * 2047 = 8188), so the sum cannot overflow.
    assign score = {2'b00, d_cx} + {2'b00, d_cy} + {2'b00, d_w} + {2'b00, d_h};

    // Candidate minimum, updated only on a strictly smaller score so a tie keeps the lower index
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        next_min = run_min;
        next_idx = run_idx;
        if (score < run_min) begin
            next_min = score;
            next_idx = scan_idx;
        end
    end

    // Table writes, accepted only while idle
    always_ff @(posedge clk) begin
        if (reset_N) begin
            // NOTE: this table is small and has to read as zero after reset, so it is built from flops rather than RAM. Larger memories are normally left unreset.
            for (int i = 0; i < ENTRIES; i++) begin
                tab_cx[i] <= '0;
                tab_cy[i] <= '0;
                tab_w[i]  <= '0;
                tab_h[i]  <= '0;
            end
        end else if (prev_wr_en && (state == S_IDLE)) begin
            tab_cx[prev_wr_addr] <= prev_cm_concate[21:11];
            tab_cy[prev_wr_addr] <= prev_cm_concate[10:0];
            tab_w[prev_wr_addr]  <= prev_width;
            tab_h[prev_wr_addr]  <= prev_height;
        end
    end

    // Search FSM: latch the request, scan the entries, publish the registered result
    always_ff @(posedge clk) begin
        if (reset_N) begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            state       <= S_IDLE;
            cur_cx      <= '0;
            cur_cy      <= '0;
            cur_w       <= '0;
            cur_h       <= '0;
            scan_cnt    <= '0;
            scan_idx    <= '0;
            run_min     <= SCORE_MAX;
            run_idx     <= '0;
            best_idx    <= '0;
            best_score  <= '0;
            match_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_cx   <= cm_concate[21:11];
                        cur_cy   <= cm_concate[10:0];
                        cur_w    <= width;
                        cur_h    <= height;
                        scan_cnt <= count_clamped;
                        scan_idx <= '0;
                        run_min  <= SCORE_MAX;
                        run_idx  <= '0;
                        if (count_clamped == 4'd0) begin
                            // An empty table goes straight to the result with the "no match" values.
                            state       <= S_DONE;
                            best_idx    <= '0;
                            best_score  <= SCORE_MAX;
                            match_valid <= 1'b0;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    run_min  <= next_min;
                    run_idx  <= next_idx;
                    scan_idx <= scan_idx + 3'd1;
                    if (last_entry) begin
                        // The last entry is folded into the result directly, so done comes without an extra cycle.
                        state       <= S_DONE;
                        best_idx    <= next_idx;
                        best_score  <= next_min;
                        match_valid <= (32'(next_min) <= THRESHOLD);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_oflow_match_search.sv
// tb_oflow_match_search
// Scoreboard bench. Each search pushes the expected result and the expected
// done cycle. A negedge monitor pops one entry per done pulse and compares it.
`timescale 1ns/1ps
module tb_oflow_match_search;

    localparam int unsigned THRESHOLD = 200;

    typedef struct {
        logic [2:0]  idx;
        logic [12:0] score;
        logic        valid;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_N = 1'b1;
    logic        prev_wr_en = 1'b0;
    logic [2:0]  prev_wr_addr = '0;
    logic [21:0] prev_cm_concate = '0;
    logic [10:0] prev_width = '0;
    logic [10:0] prev_height = '0;
    logic [3:0]  prev_count = '0;
    logic        start = 1'b0;
    logic [21:0] cm_concate = '0;
    logic [10:0] width = '0;
    logic [10:0] height = '0;
    logic        busy;
    logic        done;
    logic [2:0]  best_idx;
    logic [12:0] best_score;
    logic        match_valid;

    oflow_match_search #(.THRESHOLD(THRESHOLD)) dut (
        .clk             (clk),
        .reset_N         (reset_N),
        .prev_wr_en      (prev_wr_en),
        .prev_wr_addr    (prev_wr_addr),
        .prev_cm_concate (prev_cm_concate),
        .prev_width      (prev_width),
        .prev_height     (prev_height),
        .prev_count      (prev_count),
        .start           (start),
        .cm_concate      (cm_concate),
        .width           (width),
        .height          (height),
        .busy            (busy),
        .done            (done),
        .best_idx        (best_idx),
        .best_score      (best_score),
        .match_valid     (match_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Reference table of what the DUT should hold
    int m_cx[8], m_cy[8], m_w[8], m_h[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model(input int n, input int cx, input int cy, input int w, input int h);
        exp_t r;
        int   best;
        int   s;
        best = 8191;
        r.idx = '0;
        for (int i = 0; i < n; i++) begin
            s = iabs(cx - m_cx[i]) + iabs(cy - m_cy[i]) + iabs(w - m_w[i]) + iabs(h - m_h[i]);
            if (s < best) begin
                best = s;
                r.idx = 3'(i);
            end
        end
        r.score = 13'(best);
        r.valid = (n > 0) && (best <= int'(THRESHOLD));
        r.cyc = 0;
        return r;
    endfunction

    // Done monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("best_idx", 32'(best_idx), 32'(e.idx));
                check("best_score", 32'(best_score), 32'(e.score));
                check("match_valid", 32'(match_valid), 32'(e.valid));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    // Drive write data and record it in the reference table (enable is driven separately)
    task automatic stage_write(input int a, input int cx, input int cy, input int w, input int h);
        prev_wr_addr    = 3'(a);
        prev_cm_concate = {11'(cx), 11'(cy)};
        prev_width      = 11'(w);
        prev_height     = 11'(h);
        m_cx[a] = cx; m_cy[a] = cy; m_w[a] = w; m_h[a] = h;
    endtask

    task automatic wr(input int a, input int cx, input int cy, input int w, input int h);
        @(posedge clk); #1;
        stage_write(a, cx, cy, w, h);
        prev_wr_en = 1'b1;
        @(posedge clk); #1;
        prev_wr_en = 1'b0;
    endtask

    // Issue a start. On return the start edge has passed.
    task automatic launch(input int cnt, input int cx, input int cy, input int w, input int h,
                          input bit push, input bit with_wr);
        exp_t e;
        int   n;
        n = (cnt > 8) ? 8 : cnt;
        @(posedge clk); #1;
        e = model(n, cx, cy, w, h);
        e.cyc = cyc + 1 + n;
        prev_count = 4'(cnt);
        cm_concate = {11'(cx), 11'(cy)};
        width      = 11'(w);
        height     = 11'(h);
        start      = 1'b1;
        if (with_wr) prev_wr_en = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        start      = 1'b0;
        prev_wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic search(input int cnt, input int cx, input int cy, input int w, input int h);
        launch(cnt, cx, cy, w, h, 1'b1, 1'b0);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_done"},  32'(done),        32'd0);
        check({tag, "_idx"},   32'(best_idx),    32'd0);
        check({tag, "_score"}, 32'(best_score),  32'd0);
        check({tag, "_valid"}, 32'(match_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_w[i] = 0; m_h[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_N = 1'b0;

        // Closest of two entries
        wr(0, 510, 250, 20, 30);
        wr(1, 500, 252, 21, 30);
        search(2, 500, 250, 20, 30);

        // Second start and table write while busy are both dropped
        launch(2, 500, 250, 20, 30, 1'b1, 1'b0);
        start           = 1'b1;
        prev_wr_en      = 1'b1;
        prev_wr_addr    = 3'd0;
        prev_cm_concate = {11'd500, 11'd250};
        prev_width      = 11'd20;
        prev_height     = 11'd30;
        @(posedge clk); #1;
        start      = 1'b0;
        prev_wr_en = 1'b0;
        wait_idle();
        search(1, 510, 250, 20, 30);

        // Four-way tie keeps index 0
        for (int i = 0; i < 4; i++) wr(i, 505, 250, 20, 30);
        search(4, 500, 250, 20, 30);

        // Empty table: done in the first cycle, busy for one cycle only
        launch(0, 500, 250, 20, 30, 1'b1, 1'b0);
        @(negedge clk);
        check("cnt0_busy_c1", 32'(busy), 32'd1);
        @(negedge clk);
        check("cnt0_busy_c2", 32'(busy), 32'd0);
        wait_idle();

        // Far entry does not match
        wr(0, 800, 250, 20, 30);
        search(1, 500, 250, 20, 30);

        // Threshold boundary: 200 matches, 201 does not
        wr(0, 700, 250, 20, 30);
        search(1, 500, 250, 20, 30);
        wr(0, 701, 250, 20, 30);
        search(1, 500, 250, 20, 30);

        // A write coinciding with start is seen by the scan
        stage_write(0, 123, 45, 6, 7);
        launch(1, 120, 45, 6, 7, 1'b1, 1'b1);
        wait_idle();

        // Random tables, including a count above 8 that clamps to 8
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++)
                wr(i, $urandom_range(400, 600), $urandom_range(200, 300),
                   $urandom_range(10, 40), $urandom_range(10, 40));
            search((t == 0) ? 15 : $urandom_range(1, 8), 500, 250, 25, 25);
        end

        // Reset in the fourth SCAN cycle aborts with no done pulse
        launch(8, 500, 250, 20, 30, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_N = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        reset_N = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_w[i] = 0; m_h[i] = 0;
        end
        repeat (10) @(posedge clk);
        search(0, 500, 250, 20, 30);

        // Table reads as zero after reset
        search(1, 3, 4, 5, 6);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oflow_match_search.md
OFLOW_MATCH_SEARCH -- requirements
Module: oflow_match_search

Interface
REQ-001 Parameter THRESHOLD, default 200, SHALL set the maximum score accepted as a match.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_N  in  1  SHALL be a synchronous, active-high reset (1 = reset).
REQ-004 prev_wr_en  in  1  SHALL write one previous-frame table entry.
REQ-005 prev_wr_addr  in  3  SHALL select the table entry, 0..7.
REQ-006 prev_cm_concate  in  22  SHALL carry the previous centre of mass, {cx[10:0], cy[10:0]}.
REQ-007 prev_width / prev_height  in  11 each  SHALL carry the previous object size.
REQ-008 prev_count  in  4  SHALL give the number of valid table entries, 0..8.
REQ-009 start  in  1  SHALL request a search for the current object.
REQ-010 cm_concate  in  22  SHALL carry the current centre of mass, {cx, cy}, from feature extraction.
REQ-011 width / height  in  11 each  SHALL carry the current object size from feature extraction.
REQ-012 busy  out  1  SHALL be high while a search is in progress.
REQ-013 done  out  1  SHALL be a one-cycle pulse when the result is ready.
REQ-014 best_idx  out  3  SHALL give the index of the best-matching entry.
REQ-015 best_score  out  13  SHALL give the minimum score found.
REQ-016 match_valid  out  1  SHALL indicate that best_score <= THRESHOLD and prev_count > 0.

Function
REQ-017 The table SHALL hold 8 entries (cx, cy, w, h; 11 bits each), written on prev_wr_en only while in IDLE; writes in any other state SHALL be ignored.
REQ-018 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-019 IDLE -> SCAN on start: the block SHALL latch the current cx, cy, w and h, and latch prev_count clamped to 8.
REQ-020 IDLE -> DONE on start when the latched count = 0.
REQ-021 SCAN SHALL evaluate one entry per cycle, index 0..count-1, then go to DONE after the last entry.
REQ-022 Score SHALL be |cx-pcx| + |cy-pcy| + |w-pw| + |h-ph|, with unsigned 11-bit absolute differences and a 13-bit sum (max 8188), with no overflow.
REQ-023 The running minimum SHALL initialise to 8191 and update only on strictly-less, so a tie keeps the lowest index.
REQ-024 In DONE, done = 1 for exactly one cycle, best_idx, best_score and match_valid SHALL be registered, and the FSM SHALL return to IDLE.
REQ-025 Latency: done SHALL be high in cycle count+1 after the start-sampling edge (cycle 1 for count = 0).
REQ-026 For count = 0: best_idx = 0, best_score = 8191, match_valid = 0.
REQ-027 best_idx, best_score and match_valid SHALL hold until the next DONE.
REQ-028 busy SHALL be high in SCAN and DONE and low in IDLE.
REQ-029 start SHALL be ignored while busy = 1.
REQ-030 start coincident with prev_wr_en in IDLE: the write SHALL complete and the search SHALL start, but the new entry is visible only because scanning begins next cycle.

Reset
REQ-031 While reset_N = 1 at a clock edge, the FSM SHALL go to IDLE and all table entries SHALL clear to 0.
REQ-032 During reset: busy = 0, done = 0, best_idx = 0, best_score = 0, match_valid = 0.
REQ-033 Reset mid-SCAN SHALL abort the search with no done pulse, and outputs SHALL take the reset values.

Verification
REQ-034 Entries 0 = (510,250,20,30), 1 = (500,252,21,30), prev_count = 2, current (500,250,20,30), start -> done at cycle 3, best_idx = 1, best_score = 3, match_valid = 1.
REQ-035 Entries 0..3 all = (505,250,20,30), prev_count = 4, current (500,250,20,30) -> best_idx = 0, best_score = 5 (tie rule), done at cycle 5.
REQ-036 prev_count = 0, start -> done at cycle 1, best_score = 8191, match_valid = 0, busy high for 1 cycle.
REQ-037 Single entry (800,250,20,30), current (500,250,20,30) -> best_score = 300, best_idx = 0, match_valid = 0.
REQ-038 prev_count = 8, reset_N = 1 at SCAN cycle 4 -> no done pulse, all outputs 0, busy = 0; a subsequent start with prev_count = 0 -> done after 1 cycle.
REQ-039 A second start and prev_wr_en to entry 0 while busy -> both ignored; result and table unchanged.
